// File: rtl/pattern_search_pkg.sv
// pattern_search_pkg: shared FSM encoding and default widths for the pattern search engine
package pattern_search_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        FETCH = 3'd2,
        CMP   = 3'd3,
        HIT   = 3'd4,
        SLIDE = 3'd5,
        DONE  = 3'd6
    } state_t;
    localparam int DEF_CHAR_W  = 8;
    localparam int DEF_PAT_MAX = 16;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_CNT_W   = 8;
endpackage

// File: rtl/pattern_store.sv
// pattern_store: pattern character register file, sync write, async read
module pattern_store #(
    parameter int CHAR_W  = 8,
    parameter int PAT_MAX = 16,
    parameter int PI_W    = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PI_W-1:0]   waddr,
    input  logic [CHAR_W-1:0] wdata,
    input  logic [PI_W-1:0]   raddr,
    output logic [CHAR_W-1:0] rdata
);
    logic [CHAR_W-1:0] mem [PAT_MAX];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/pattern_search_engine.sv
// pattern_search_engine: finds every occurrence of a stored pattern in an external text memory
module pattern_search_engine
    import pattern_search_pkg::*;
#(
    parameter int CHAR_W  = DEF_CHAR_W,
    parameter int PAT_MAX = DEF_PAT_MAX,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int OVERLAP = 1,
    localparam int PI_W   = $clog2(PAT_MAX),
    localparam int PL_W   = $clog2(PAT_MAX + 1),
    localparam int AW2    = ADDR_W + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pat_we,
    input  logic [PI_W-1:0]   pat_addr,
    input  logic [CHAR_W-1:0] pat_data,
    input  logic [PL_W-1:0]   pat_len,
    input  logic [ADDR_W:0]   text_len,
    input  logic              start,
    output logic              txt_rd,
    output logic [ADDR_W-1:0] txt_addr,
    input  logic [CHAR_W-1:0] txt_data,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [ADDR_W-1:0] first_pos,
    output logic              match_pulse,
    output logic [ADDR_W-1:0] match_pos,
    output logic [CNT_W-1:0]  match_count,
    output logic [2:0]        actual_state
);
    state_t            state, state_nxt;
    logic [PL_W-1:0]   plen, plen_in;
    logic [ADDR_W:0]   tlen, win;
    logic [PI_W-1:0]   pidx;
    logic [CHAR_W-1:0] pat_char;
    logic              overflow, last, eq;

    pattern_store #(.CHAR_W(CHAR_W), .PAT_MAX(PAT_MAX), .PI_W(PI_W)) u_store (
        .clk   (clk),
        .we    (pat_we && state == IDLE),
        .waddr (pat_addr),
        .wdata (pat_data),
        .raddr (pidx),
        .rdata (pat_char)
    );

    assign plen_in  = pat_len > PL_W'(PAT_MAX) ? PL_W'(PAT_MAX) : pat_len;
    // widened compare so a window near the end of a full-size buffer cannot wrap
    assign overflow = ({1'b0, win} + AW2'(plen)) > {1'b0, tlen};
    assign last     = PL_W'(pidx) == plen - PL_W'(1);
    assign eq       = txt_data == pat_char;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       state_nxt = start ? CHECK : IDLE;
            CHECK:      state_nxt = (plen == '0 || overflow) ? DONE : FETCH;
            FETCH:      state_nxt = CMP;
            CMP:        state_nxt = !eq ? SLIDE : last ? HIT : FETCH;
            HIT, SLIDE: state_nxt = CHECK;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy         = state != IDLE;
        done         = state == DONE;
        txt_rd       = state == FETCH;
        match_pulse  = state == HIT;
        txt_addr     = ADDR_W'(win + (ADDR_W+1)'(pidx));
        match_pos    = ADDR_W'(win);
        actual_state = state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            plen        <= '0;
            tlen        <= '0;
            win         <= '0;
            pidx        <= '0;
            found       <= 1'b0;
            first_pos   <= '0;
            match_count <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    plen        <= plen_in;
                    tlen        <= text_len;
                    win         <= '0;
                    pidx        <= '0;
                    found       <= 1'b0;
                    first_pos   <= '0;
                    match_count <= '0;
                end
                CMP: if (eq && !last) pidx <= pidx + PI_W'(1);
                HIT: begin
                    if (match_count != '1) match_count <= match_count + CNT_W'(1);
                    if (!found) begin
                        found     <= 1'b1;
                        first_pos <= ADDR_W'(win);
                    end
                    win  <= win + ((OVERLAP != 0) ? (ADDR_W+1)'(1) : (ADDR_W+1)'(plen));
                    pidx <= '0;
                end
                SLIDE: begin
                    win  <= win + (ADDR_W+1)'(1);
                    pidx <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pattern_search_engine.sv
// tb_pattern_search_engine: directed vectors run on overlap, non-overlap and 2-bit-counter instances
module tb_pattern_search_engine;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pat_we = 1'b0;
    logic [3:0] pat_addr = '0;
    logic [7:0] pat_data = '0;
    logic [4:0] pat_len = '0;
    logic [8:0] text_len = '0;
    logic       start = 1'b0;

    logic       txt_rd [3];
    logic [7:0] txt_addr [3];
    logic [7:0] rdata [3];
    logic       busy [3];
    logic       done [3];
    logic       found [3];
    logic [7:0] first_pos [3];
    logic       match_pulse [3];
    logic [7:0] match_pos [3];
    logic [2:0] st [3];
    logic [7:0] cnt [3];
    logic [1:0] cnt2;
    logic [7:0] mem [256];

    int total = 0;
    int bad = 0;
    int cur_v = 0;

    always #5 clk = ~clk;

    pattern_search_engine #(.OVERLAP(1)) u0 (
        .clk(clk), .rst(rst), .pat_we(pat_we), .pat_addr(pat_addr), .pat_data(pat_data),
        .pat_len(pat_len), .text_len(text_len), .start(start), .txt_rd(txt_rd[0]),
        .txt_addr(txt_addr[0]), .txt_data(rdata[0]), .busy(busy[0]), .done(done[0]),
        .found(found[0]), .first_pos(first_pos[0]), .match_pulse(match_pulse[0]),
        .match_pos(match_pos[0]), .match_count(cnt[0]), .actual_state(st[0]));

    pattern_search_engine #(.OVERLAP(0)) u1 (
        .clk(clk), .rst(rst), .pat_we(pat_we), .pat_addr(pat_addr), .pat_data(pat_data),
        .pat_len(pat_len), .text_len(text_len), .start(start), .txt_rd(txt_rd[1]),
        .txt_addr(txt_addr[1]), .txt_data(rdata[1]), .busy(busy[1]), .done(done[1]),
        .found(found[1]), .first_pos(first_pos[1]), .match_pulse(match_pulse[1]),
        .match_pos(match_pos[1]), .match_count(cnt[1]), .actual_state(st[1]));

    pattern_search_engine #(.CNT_W(2), .OVERLAP(1)) u2 (
        .clk(clk), .rst(rst), .pat_we(pat_we), .pat_addr(pat_addr), .pat_data(pat_data),
        .pat_len(pat_len), .text_len(text_len), .start(start), .txt_rd(txt_rd[2]),
        .txt_addr(txt_addr[2]), .txt_data(rdata[2]), .busy(busy[2]), .done(done[2]),
        .found(found[2]), .first_pos(first_pos[2]), .match_pulse(match_pulse[2]),
        .match_pos(match_pos[2]), .match_count(cnt2), .actual_state(st[2]));

    assign cnt[2] = {6'b0, cnt2};

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++)
            if (txt_rd[k]) rdata[k] <= mem[txt_addr[k]];
    end

    // p0/s0: pulse count and position sum with overlap; p1/s1: without; lat 0 = not checked
    typedef struct {
        logic [63:0] text;
        int tlen;
        logic [31:0] pat;
        int pn;
        int plen;
        int p0;
        int p1;
        int s0;
        int s1;
        int first;
        int lat;
    } vec_t;
    vec_t vt [10];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL v%0d %s: got %0d want %0d", cur_v, nm, act, exp);
        end
    endtask

    task automatic setup(input int v);
        vec_t t = vt[v];
        cur_v = v;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < t.tlen; i++) mem[i] = t.text[8*(t.tlen-1-i) +: 8];
        for (int i = 0; i < t.pn; i++) begin
            @(negedge clk);
            pat_we = 1'b1;
            pat_addr = 4'(i);
            pat_data = t.pat[8*(t.pn-1-i) +: 8];
        end
        @(negedge clk);
        pat_we = 1'b0;
        pat_len = 5'(t.plen);
        text_len = 9'(t.tlen);
        start = 1'b1;
    endtask

    task automatic run(input int v, input bit poke);
        vec_t t = vt[v];
        int pulses [3] = '{0, 0, 0};
        int psum [3] = '{0, 0, 0};
        int dones [3] = '{0, 0, 0};
        int lat [3] = '{0, 0, 0};
        int c = 0;
        bit all = 1'b0;
        setup(v);
        while (!all && c < 2000) begin
            @(negedge clk);
            c++;
            for (int k = 0; k < 3; k++) begin
                if (match_pulse[k]) begin
                    pulses[k]++;
                    psum[k] += int'(match_pos[k]);
                end
                if (done[k]) begin
                    dones[k]++;
                    if (lat[k] == 0) lat[k] = c;
                end
            end
            if (c == 1) begin
                start = 1'b0;
                chk("busy_after_start", int'(busy[0]), 1);
            end
            if (poke && c == 4) begin
                start = 1'b1;
                pat_we = 1'b1;
                pat_addr = 4'd0;
                pat_data = "Z";
            end
            if (poke && c == 5) begin
                start = 1'b0;
                pat_we = 1'b0;
            end
            all = dones[0] > 0 && dones[1] > 0 && dones[2] > 0;
        end
        chk("finished", int'(all), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) dones[k] += int'(done[k]);
        end
        chk("count0", int'(cnt[0]), t.p0);
        chk("count1", int'(cnt[1]), t.p1);
        chk("count2_sat", int'(cnt[2]), t.p0 > 3 ? 3 : t.p0);
        chk("pulses0", pulses[0], t.p0);
        chk("pulses1", pulses[1], t.p1);
        chk("pulses2", pulses[2], t.p0);
        chk("possum0", psum[0], t.s0);
        chk("possum1", psum[1], t.s1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("found%0d", k), int'(found[k]), t.p0 > 0 ? 1 : 0);
            chk($sformatf("first_pos%0d", k), int'(first_pos[k]), t.first);
            chk($sformatf("done_once%0d", k), dones[k], 1);
            chk($sformatf("idle%0d", k), int'(busy[k]), 0);
            if (t.lat != 0) chk($sformatf("latency%0d", k), lat[k], t.lat);
        end
    endtask

    initial begin
        int c;
        int nd;
        vt[0] = '{"ABABA",  5, "ABA",  3, 3, 2, 1,  2, 0, 0, 0};
        vt[1] = '{"ABABA",  5, "XYZ",  3, 3, 0, 0,  0, 0, 0, 0};
        vt[2] = '{"AAAAAA", 6, "A",    1, 1, 6, 6, 15, 15, 0, 0};
        vt[3] = '{"ABABA",  5, "ABA",  3, 0, 0, 0,  0, 0, 0, 2};
        vt[4] = '{"ABABA",  5, "ABA",  3, 6, 0, 0,  0, 0, 0, 2};
        vt[5] = '{"AAAAAA", 6, "AA",   2, 2, 5, 3, 10, 6, 0, 0};
        vt[6] = '{"XXABC",  5, "ABC",  3, 3, 1, 1,  2, 2, 2, 0};
        vt[7] = '{"CABAB",  5, "AB",   2, 2, 2, 2,  4, 4, 1, 0};
        vt[8] = '{"ABCD",   4, "ABCD", 4, 4, 1, 1,  0, 0, 0, 0};
        vt[9] = '{"ABCABC", 6, "ABC",  3, 3, 2, 2,  3, 3, 0, 0};

        repeat (3) @(negedge clk);
        cur_v = -1;
        chk("rst_state", int'(st[0]), 0);
        chk("rst_busy", int'(busy[0]), 0);
        chk("rst_done", int'(done[0]), 0);
        chk("rst_found", int'(found[0]), 0);
        chk("rst_count", int'(cnt[0]), 0);
        chk("rst_first_pos", int'(first_pos[0]), 0);
        chk("rst_match_pulse", int'(match_pulse[0]), 0);
        chk("rst_txt_rd", int'(txt_rd[0]), 0);
        rst = 1'b0;

        for (int v = 0; v < 10; v++) run(v, 1'b0);

        // reset in the middle of a search, then restart with ignored start/pat_we pokes
        setup(0);
        c = 0;
        @(negedge clk);
        start = 1'b0;
        while (st[0] != 3'd2 && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("reached_fetch", int'(st[0]), 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_state", int'(st[0]), 0);
        chk("midrst_busy", int'(busy[0]), 0);
        chk("midrst_count", int'(cnt[0]), 0);
        chk("midrst_found", int'(found[0]), 0);
        nd = 0;
        repeat (20) begin
            @(negedge clk);
            nd += int'(done[0]) + int'(done[1]) + int'(done[2]);
        end
        chk("midrst_no_done", nd, 0);
        run(0, 1'b1);
        run(2, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
